// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I controllers: FSM states, opcodes and the
// select/control codes driven toward the datapath.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus the instruction function fields to an ALUControl code.
// Shared with the single-cycle core.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] aluOp_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [2:0] aluControl_o
);

   // Only R-type (op5 set) with funct7b5 selects subtract; addi never does.
   always_comb begin
      aluControl_o = ALU_ADD;
      case (aluOp_i)
         ALUOP_ADD: aluControl_o = ALU_ADD;
         ALUOP_SUB: aluControl_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               3'b000:  aluControl_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  aluControl_o = ALU_SLT;
               3'b110:  aluControl_o = ALU_OR;
               3'b111:  aluControl_o = ALU_AND;
               default: aluControl_o = ALU_ADD;
            endcase
         end
         default: aluControl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main Moore FSM for the multicycle RV32I core, sequencing the shared
// memory/ALU datapath, plus immediate-format decode.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = S_FETCH
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [2:0] ALUControl,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic       IllegalOp
);

   state_t     state_q, state_d, decState;
   logic       pcUpdate, branch, adrSrc, memWrite, irWrite, regWrite, illegal;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;

   always_ff @(posedge clk) begin
      if (reset) state_q <= RESET_STATE;
      else       state_q <= state_d;
   end

   // While reset is held the outputs show the fetch decode, so nothing
   // partially completes for an abandoned instruction.
   always_comb begin
      decState  = reset ? S_FETCH : state_q;
      state_d   = S_FETCH;
      pcUpdate  = 1'b0;
      branch    = 1'b0;
      adrSrc    = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      regWrite  = 1'b0;
      illegal   = 1'b0;
      resultSrc = RES_ALUOUT;
      aluSrcA   = SRCA_PC;
      aluSrcB   = SRCB_RS2;
      aluOp     = ALUOP_ADD;
      case (decState)
         S_FETCH: begin
            irWrite   = 1'b1;
            aluSrcB   = SRCB_FOUR;
            resultSrc = RES_ALURESULT;
            pcUpdate  = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            aluSrcA = SRCA_OLDPC;
            aluSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            aluSrcA = SRCA_RS1;
            aluSrcB = SRCB_IMM;
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adrSrc  = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultSrc = RES_DATA;
            regWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            adrSrc   = 1'b1;
            memWrite = 1'b1;
         end
         S_EXECR: begin
            aluSrcA = SRCA_RS1;
            aluOp   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            aluSrcA = SRCA_RS1;
            aluSrcB = SRCB_IMM;
            aluOp   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: regWrite = 1'b1;
         S_JAL: begin
            aluSrcA  = SRCA_OLDPC;
            aluSrcB  = SRCB_FOUR;
            pcUpdate = 1'b1;
            state_d  = S_ALUWB;
         end
         S_BEQ: begin
            aluSrcA = SRCA_RS1;
            aluOp   = ALUOP_SUB;
            branch  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      case (op)
         OP_LW, OP_I: ImmSrc = IMM_I;
         OP_SW:       ImmSrc = IMM_S;
         OP_BEQ:      ImmSrc = IMM_B;
         OP_JAL:      ImmSrc = IMM_J;
         default:     ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_aluDecoder (
      .aluOp_i      (aluOp),
      .funct3_i     (funct3),
      .funct7b5_i   (funct7b5),
      .op5_i        (op[5]),
      .aluControl_o (ALUControl)
   );

   assign PCWrite   = ~reset & (pcUpdate | (branch & Zero));
   assign MemWrite  = ~reset & memWrite;
   assign RegWrite  = ~reset & regWrite;
   assign IRWrite   = ~reset & irWrite;
   assign IllegalOp = ~reset & illegal;
   assign AdrSrc    = adrSrc;
   assign ResultSrc = resultSrc;
   assign ALUSrcA   = aluSrcA;
   assign ALUSrcB   = aluSrcB;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle vector table scored against a reference
// model through a queue, plus directed multi-cycle corner sequences.
module tb_multicycle_controller;

   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam logic [6:0] T_BEQ = 7'b1100011;
   localparam logic [6:0] T_BAD = 7'b0000000;

   typedef enum {B_F, B_D, B_MA, B_MR, B_MWB, B_MWR, B_ER, B_EI, B_AWB, B_J, B_BEQ} bstate_t;

   typedef struct {
      bit         rst;
      logic [6:0] op;
      logic [2:0] f3;
      bit         f7;
      bit         z;
      bstate_t    st;
   } row_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = T_LW;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   row_t        rows[$];
   logic [16:0] expQ[$];
   int          idQ[$];
   int          passCount = 0;
   int          totalCount = 0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .IllegalOp(IllegalOp)
   );

   always #5 clk = ~clk;

   // Reference outputs for a cycle, given the state the bench expects.
   function automatic logic [16:0] expOut(row_t r);
      bstate_t    s;
      logic       pcu, br, adr, mw, irw, rw, ill, pcw;
      logic [1:0] res, sa, sb, aop, imm;
      logic [2:0] ctl;
      s = r.rst ? B_F : r.st;
      {pcu, br, adr, mw, irw, rw, ill} = '0;
      res = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
      case (s)
         B_F:   begin irw = 1; sb = 2'b10; res = 2'b10; pcu = 1; end
         B_D:   begin sa = 2'b01; sb = 2'b01;
                      ill = !(r.op inside {T_LW, T_SW, T_R, T_I, T_JAL, T_BEQ}); end
         B_MA:  begin sa = 2'b10; sb = 2'b01; end
         B_MR:  adr = 1;
         B_MWB: begin res = 2'b01; rw = 1; end
         B_MWR: begin adr = 1; mw = 1; end
         B_ER:  begin sa = 2'b10; aop = 2'b10; end
         B_EI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         B_AWB: rw = 1;
         B_J:   begin sa = 2'b01; sb = 2'b10; pcu = 1; end
         B_BEQ: begin sa = 2'b10; aop = 2'b01; br = 1; end
         default: ;
      endcase
      pcw = (pcu | (br & r.z)) & !r.rst;
      if (r.rst) begin mw = 0; rw = 0; irw = 0; ill = 0; end
      ctl = 3'b000;
      if (aop == 2'b01) ctl = 3'b001;
      else if (aop == 2'b10) begin
         if (r.f3 == 3'b000 && r.f7 && r.op[5]) ctl = 3'b001;
         else if (r.f3 == 3'b010) ctl = 3'b101;
         else if (r.f3 == 3'b110) ctl = 3'b011;
         else if (r.f3 == 3'b111) ctl = 3'b010;
      end
      imm = (r.op == T_SW) ? 2'b01 : (r.op == T_BEQ) ? 2'b10 : (r.op == T_JAL) ? 2'b11 : 2'b00;
      return {pcw, adr, mw, irw, res, ctl, sa, sb, imm, rw, ill};
   endfunction

   function automatic logic [16:0] dutOut();
      return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
              ALUSrcA, ALUSrcB, ImmSrc, RegWrite, IllegalOp};
   endfunction

   task automatic checkOutput(input string name, input logic [16:0] act, input logic [16:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic addRow(input bit rst, input logic [6:0] o, input logic [2:0] f3,
                         input bit f7, input bit z, input bstate_t st);
      row_t r;
      r.rst = rst; r.op = o; r.f3 = f3; r.f7 = f7; r.z = z; r.st = st;
      rows.push_back(r);
   endtask

   task automatic addSeq(input logic [6:0] o, input logic [2:0] f3, input bit f7, input bit z,
                         input int n, input bstate_t s0, input bstate_t s1, input bstate_t s2,
                         input bstate_t s3, input bstate_t s4);
      bstate_t sl[5];
      sl = '{s0, s1, s2, s3, s4};
      for (int i = 0; i < n; i++) addRow(1'b0, o, f3, f7, z, sl[i]);
   endtask

   task automatic applyStimulus(input bit rst, input logic [6:0] o, input logic [2:0] f3,
                                input bit f7, input bit z);
      reset = rst; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1'b1, T_LW, 3'b000, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      addRow(1'b1, T_LW, 3'b000, 1'b0, 1'b0, B_F);
      addRow(1'b1, T_LW, 3'b000, 1'b0, 1'b0, B_F);
      addSeq(T_LW,  3'b010, 0, 0, 5, B_F, B_D, B_MA, B_MR,  B_MWB);
      addSeq(T_SW,  3'b010, 0, 1, 4, B_F, B_D, B_MA, B_MWR, B_F);
      addSeq(T_R,   3'b000, 1, 1, 4, B_F, B_D, B_ER, B_AWB, B_F);
      addSeq(T_R,   3'b000, 0, 0, 4, B_F, B_D, B_ER, B_AWB, B_F);
      addSeq(T_R,   3'b111, 0, 1, 4, B_F, B_D, B_ER, B_AWB, B_F);
      addSeq(T_R,   3'b110, 0, 0, 4, B_F, B_D, B_ER, B_AWB, B_F);
      addSeq(T_R,   3'b010, 0, 0, 4, B_F, B_D, B_ER, B_AWB, B_F);
      addSeq(T_R,   3'b001, 1, 0, 4, B_F, B_D, B_ER, B_AWB, B_F);
      addSeq(T_I,   3'b000, 1, 0, 4, B_F, B_D, B_EI, B_AWB, B_F);
      addSeq(T_I,   3'b010, 0, 1, 4, B_F, B_D, B_EI, B_AWB, B_F);
      addSeq(T_BEQ, 3'b000, 0, 1, 3, B_F, B_D, B_BEQ, B_F, B_F);
      addSeq(T_BEQ, 3'b000, 0, 0, 3, B_F, B_D, B_BEQ, B_F, B_F);
      addSeq(T_JAL, 3'b000, 0, 0, 4, B_F, B_D, B_J,  B_AWB, B_F);
      addSeq(T_BAD, 3'b000, 0, 0, 2, B_F, B_D, B_F,  B_F,   B_F);
      addSeq(T_SW,  3'b010, 0, 0, 3, B_F, B_D, B_MA, B_F,   B_F);
      addRow(1'b1, T_SW, 3'b010, 1'b0, 1'b0, B_MWR);
      addSeq(T_LW,  3'b010, 0, 0, 5, B_F, B_D, B_MA, B_MR,  B_MWB);

      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus(rows[i].rst, rows[i].op, rows[i].f3, rows[i].f7, rows[i].z);
         expQ.push_back(expOut(rows[i]));
         idQ.push_back(i);
         @(negedge clk);
         checkOutput($sformatf("row%0d", idQ.pop_front()), dutOut(), expQ.pop_front());
         tick();
      end

      // sw: single write strobe in cycle 4, then straight back to fetch
      doReset();
      for (int c = 1; c <= 5; c++) begin
         applyStimulus(1'b0, T_SW, 3'b010, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput($sformatf("sw_memwrite_c%0d", c), 17'(MemWrite), 17'(c == 4));
         if (c == 4) checkOutput("sw_adrsrc_c4", 17'(AdrSrc), 17'd1);
         if (c == 5) checkOutput("sw_refetch_c5", 17'(IRWrite), 17'd1);
         tick();
      end

      // beq not taken: PC only moves in fetch; done in 3 cycles
      doReset();
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(1'b0, T_BEQ, 3'b000, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput($sformatf("beq_nt_pcwrite_c%0d", c), 17'(PCWrite), 17'(c == 1 || c == 4));
         if (c == 4) checkOutput("beq_nt_refetch_c4", 17'(IRWrite), 17'd1);
         tick();
      end

      // jal: J immediate, PC write in S_JAL, link write in cycle 4
      doReset();
      for (int c = 1; c <= 5; c++) begin
         applyStimulus(1'b0, T_JAL, 3'b000, 1'b0, 1'b0);
         @(negedge clk);
         if (c == 1) checkOutput("jal_immsrc", 17'(ImmSrc), 17'd3);
         if (c == 3) checkOutput("jal_pcwrite_c3", 17'(PCWrite), 17'd1);
         if (c == 4) checkOutput("jal_regwb_c4", {14'd0, RegWrite, ResultSrc}, 17'b100);
         if (c == 5) checkOutput("jal_refetch_c5", 17'(IRWrite), 17'd1);
         tick();
      end

      // reset landing on the store cycle must suppress the write
      doReset();
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(1'b0, T_SW, 3'b010, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, T_SW, 3'b010, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("rst_sw_memwrite", 17'(MemWrite), 17'd0);
      tick();
      applyStimulus(1'b0, T_SW, 3'b010, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("rst_sw_fetch", {15'd0, IRWrite, PCWrite}, 17'b11);
      tick();
      @(negedge clk);
      checkOutput("rst_sw_decode", 17'(ALUSrcA), 17'd1);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM plus ALU/immediate decoders for the multicycle RV32I core. It sequences a shared datapath over several cycles per instruction: one memory, one ALU, and the PC/IR/register-file write enables.
- Supported instructions: lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq, jal.
- Sits inside the core's top level, beside the datapath. The same top-level pins (WriteData, DataAdr, MemWrite) remain the observable interface.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (kept as a parameter for bring-up only).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  instr[6:0] from the IR
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut/Result
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  IR/OldPC enable
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 data
- ALUSrcB  output  2  00 rs2 data, 01 ImmExt, 10 constant 4
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J (combinational from op)
- RegWrite  output  1  register file write enable
- IllegalOp  output  1  one-cycle pulse when Decode sees an unsupported opcode

Behaviour:
- Moore FSM with one state register. All outputs are combinational from state, except:
  - PCWrite = PCUpdate | (Branch & Zero);
  - ALUControl and ImmSrc also depend on the instruction fields.
- Reset:
  - reset high at a rising edge puts the state in S_FETCH.
  - While reset is high, PCWrite, MemWrite, RegWrite, IRWrite and IllegalOp are forced to 0. Other outputs follow S_FETCH decode.
  - Reset mid-instruction abandons it with no partial memory or register write.
- States and outputs (unlisted signals are 0 / don't-care driven 0):
  - S_FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> S_DECODE
  - S_DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
    - 0000011 or 0100011 -> S_MEMADR
    - 0110011 -> S_EXECR
    - 0010011 -> S_EXECI
    - 1101111 -> S_JAL
    - 1100011 -> S_BEQ
    - otherwise -> S_FETCH with IllegalOp=1
  - S_MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> S_MEMREAD if op=lw, else S_MEMWRITE
  - S_MEMREAD: ResultSrc=00, AdrSrc=1 -> S_MEMWB
  - S_MEMWB: ResultSrc=01, RegWrite=1 -> S_FETCH
  - S_MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> S_FETCH
  - S_EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> S_ALUWB
  - S_EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> S_ALUWB
  - S_ALUWB: ResultSrc=00, RegWrite=1 -> S_FETCH
  - S_JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> S_ALUWB
  - S_BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> S_FETCH
- Unreachable state encodings -> S_FETCH on the next edge, with all write enables 0.
- Cycles per instruction: lw 5, sw 4, R/I 4, jal 4, beq 3.
- MemWrite is asserted in exactly one cycle per sw and never otherwise.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub if (funct7b5 & op[5]), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - any other funct3 -> add
- ImmSrc:
  - lw and I-ALU -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - otherwise 00
- ImmSrc and ALUControl are valid every cycle. The datapath must only consume them in the states listed above.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state typedef enum;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ);
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings;
  - ALUOp encoding.
- One sub-module, alu_decoder (ALUOp, funct3, funct7b5, op5 -> ALUControl), reused by the single-cycle core.
- The main FSM and the ImmSrc decode stay in multicycle_controller.

Test Plan:
- Reset for 2 cycles then release, IR holding lw (op=0000011) -> fetch, decode, memadr, memread and memwb on cycles 1-5. RegWrite=1 only in cycle 5. PCWrite=1 only in cycle 1.
- sw (op=0100011), with the datapath driving DataAdr=100 and WriteData=25 -> MemWrite=1 in cycle 4 only, AdrSrc=1 in that cycle, back in S_FETCH in cycle 5.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in S_EXECR. Same instruction with funct7b5=0 -> 000. funct3=111 -> 010.
- beq (op=1100011) with Zero=1 -> PCWrite=1 in cycle 3. With Zero=0 -> PCWrite=0 throughout cycles 2-3. Both cases take 3 cycles.
- jal (op=1101111) -> ImmSrc=11. PCWrite=1 in cycle 3 (S_JAL). RegWrite=1 in cycle 4 with ResultSrc=00.
- Illegal op=0000000 -> IllegalOp pulses in Decode, no write enables, S_FETCH next. Reset asserted during S_MEMWRITE -> MemWrite=0 that cycle, S_FETCH after the edge.
